// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-rate enable, h/v counters,
// programmable-polarity syncs, pixel coordinates, line/frame strobes and frame count.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          H_POL      = 1'b0,
  parameter bit          V_POL      = 1'b0,
  parameter int unsigned X_BITS     = 11,
  parameter int unsigned Y_BITS     = 10,
  parameter int unsigned FRAME_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  pix_en,
  output logic                  h_sync,
  output logic                  v_sync,
  output logic [X_BITS-1:0]     x,
  output logic [Y_BITS-1:0]     y,
  output logic                  active,
  output logic                  line_start,
  output logic                  frame_start,
  output logic [FRAME_BITS-1:0] frame_count
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;
  localparam int unsigned DIV_BITS = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_BITS-1:0] div, div_n;
  logic [X_BITS-1:0]   h, h_n;
  logic [Y_BITS-1:0]   v, v_n;
  logic                tick, h_wrap, v_wrap, line_n, frame_n;
  logic                hs_on, vs_on, act_n;

  // Counters advance on the divider terminal count itself rather than the
  // registered pix_en, so CLK_DIV=1 steps every clock straight out of reset.
  always_comb begin
    tick    = (div == DIV_BITS'(CLK_DIV - 1));
    h_wrap  = (h == X_BITS'(H_TOTAL - 1));
    v_wrap  = (v == Y_BITS'(V_TOTAL - 1));
    line_n  = tick && h_wrap;
    frame_n = line_n && v_wrap;
    div_n   = tick ? '0 : div + DIV_BITS'(1);
    h_n     = h;
    v_n     = v;
    if (tick)   h_n = h_wrap ? '0 : h + X_BITS'(1);
    if (line_n) v_n = v_wrap ? '0 : v + Y_BITS'(1);
    hs_on   = (h_n >= X_BITS'(HS_START)) && (h_n < X_BITS'(HS_END));
    vs_on   = (v_n >= Y_BITS'(VS_START)) && (v_n < Y_BITS'(VS_END));
    act_n   = (h_n < X_BITS'(H_ACTIVE)) && (v_n < Y_BITS'(V_ACTIVE));
  end

  // Outputs are decoded from the next counter values so they always describe
  // the (h,v) the counters hold after the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      div         <= '0;
      h           <= '0;
      v           <= '0;
      pix_en      <= 1'b0;
      h_sync      <= ~H_POL;
      v_sync      <= ~V_POL;
      x           <= '0;
      y           <= '0;
      active      <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      div         <= div_n;
      h           <= h_n;
      v           <= v_n;
      pix_en      <= (div_n == DIV_BITS'(CLK_DIV - 1));
      h_sync      <= hs_on ? H_POL : ~H_POL;
      v_sync      <= vs_on ? V_POL : ~V_POL;
      x           <= act_n ? h_n : '0;
      y           <= act_n ? v_n : '0;
      active      <= act_n;
      line_start  <= line_n;
      frame_start <= frame_n;
      if (frame_n) frame_count <= frame_count + FRAME_BITS'(1);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three configurations, directed expected
// states keyed by clock count since reset, popped and compared by per-DUT monitors.
module tb_vga_timing_gen;

  typedef struct {
    int cyc;
    bit pe, hs, vs, act, ls, fs;
    int fc, x, y;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;
  int   cyc_a = 0, cyc_b = 0, cyc_c = 0;
  int   checks = 0, errors = 0;
  exp_t qa[$], qb[$], qc[$];
  exp_t ea, eb, ec;

  // A: default 640x480 timing
  logic        pe_a, hs_a, vs_a, act_a, ls_a, fs_a;
  logic [10:0] x_a;
  logic [9:0]  y_a;
  logic [15:0] fc_a;
  // B: CLK_DIV=1, tiny raster, positive syncs, 2-bit frame count
  logic        pe_b, hs_b, vs_b, act_b, ls_b, fs_b;
  logic [3:0]  x_b;
  logic [2:0]  y_b;
  logic [1:0]  fc_b;
  // C: CLK_DIV=4, tiny raster, negative syncs
  logic        pe_c, hs_c, vs_c, act_c, ls_c, fs_c;
  logic [3:0]  x_c;
  logic [2:0]  y_c;
  logic [15:0] fc_c;

  vga_timing_gen dut_a (
    .clk(clk), .reset(rst_a), .pix_en(pe_a), .h_sync(hs_a), .v_sync(vs_a),
    .x(x_a), .y(y_a), .active(act_a), .line_start(ls_a), .frame_start(fs_a),
    .frame_count(fc_a));

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1'b1), .V_POL(1'b1),
    .X_BITS(4), .Y_BITS(3), .FRAME_BITS(2)
  ) dut_b (
    .clk(clk), .reset(rst_b), .pix_en(pe_b), .h_sync(hs_b), .v_sync(vs_b),
    .x(x_b), .y(y_b), .active(act_b), .line_start(ls_b), .frame_start(fs_b),
    .frame_count(fc_b));

  vga_timing_gen #(
    .CLK_DIV(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1'b0), .V_POL(1'b0),
    .X_BITS(4), .Y_BITS(3), .FRAME_BITS(16)
  ) dut_c (
    .clk(clk), .reset(rst_c), .pix_en(pe_c), .h_sync(hs_c), .v_sync(vs_c),
    .x(x_c), .y(y_c), .active(act_c), .line_start(ls_c), .frame_start(fs_c),
    .frame_count(fc_c));

  always @(posedge clk) begin
    cyc_a <= rst_a ? 0 : cyc_a + 1;
    cyc_b <= rst_b ? 0 : cyc_b + 1;
    cyc_c <= rst_c ? 0 : cyc_c + 1;
  end

  function automatic exp_t mk(int cyc, bit pe, bit hs, bit vs, bit act, bit ls, bit fs,
                              int fc, int x, int y);
    exp_t e;
    e.cyc = cyc; e.pe = pe; e.hs = hs; e.vs = vs; e.act = act; e.ls = ls; e.fs = fs;
    e.fc = fc; e.x = x; e.y = y;
    return e;
  endfunction

  task automatic chk(string tag, exp_t e, logic pe, logic hs, logic vs, logic act,
                     logic ls, logic fs, int fc, int x, int y);
    checks++;
    if (pe !== e.pe || hs !== e.hs || vs !== e.vs || act !== e.act || ls !== e.ls ||
        fs !== e.fs || fc != e.fc || x != e.x || y != e.y) begin
      errors++;
      $display("FAIL %s cyc %0d: got pe=%b hs=%b vs=%b act=%b ls=%b fs=%b fc=%0d x=%0d y=%0d ; want pe=%b hs=%b vs=%b act=%b ls=%b fs=%b fc=%0d x=%0d y=%0d",
               tag, e.cyc, pe, hs, vs, act, ls, fs, fc, x, y,
               e.pe, e.hs, e.vs, e.act, e.ls, e.fs, e.fc, e.x, e.y);
    end
  endtask

  task automatic missed(string tag, int cyc, int now);
    checks++;
    errors++;
    $display("FAIL %s cyc %0d: expectation not reached, now at cyc %0d", tag, cyc, now);
  endtask

  always @(negedge clk) if (!rst_a && qa.size() > 0) begin
    if (qa[0].cyc == cyc_a) begin
      ea = qa.pop_front();
      chk("A", ea, pe_a, hs_a, vs_a, act_a, ls_a, fs_a, int'(fc_a), int'(x_a), int'(y_a));
    end else if (qa[0].cyc < cyc_a) begin
      ea = qa.pop_front();
      missed("A", ea.cyc, cyc_a);
    end
  end

  always @(negedge clk) if (!rst_b && qb.size() > 0) begin
    if (qb[0].cyc == cyc_b) begin
      eb = qb.pop_front();
      chk("B", eb, pe_b, hs_b, vs_b, act_b, ls_b, fs_b, int'(fc_b), int'(x_b), int'(y_b));
    end else if (qb[0].cyc < cyc_b) begin
      eb = qb.pop_front();
      missed("B", eb.cyc, cyc_b);
    end
  end

  always @(negedge clk) if (!rst_c && qc.size() > 0) begin
    if (qc[0].cyc == cyc_c) begin
      ec = qc.pop_front();
      chk("C", ec, pe_c, hs_c, vs_c, act_c, ls_c, fs_c, int'(fc_c), int'(x_c), int'(y_c));
    end else if (qc[0].cyc < cyc_c) begin
      ec = qc.pop_front();
      missed("C", ec.cyc, cyc_c);
    end
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

    //                cyc   pe hs vs act ls fs fc  x    y
    qa.push_back(mk(    0,  0, 1, 1, 1,  0, 0, 0,  0,   0));
    qa.push_back(mk(    3,  1, 1, 1, 1,  0, 0, 0,  0,   0));
    qa.push_back(mk(    4,  0, 1, 1, 1,  0, 0, 0,  1,   0));
    qa.push_back(mk( 2559,  1, 1, 1, 1,  0, 0, 0,  639, 0));
    qa.push_back(mk( 2560,  0, 1, 1, 0,  0, 0, 0,  0,   0));
    qa.push_back(mk( 2623,  1, 1, 1, 0,  0, 0, 0,  0,   0));
    qa.push_back(mk( 2624,  0, 0, 1, 0,  0, 0, 0,  0,   0));
    qa.push_back(mk( 3007,  1, 0, 1, 0,  0, 0, 0,  0,   0));
    qa.push_back(mk( 3008,  0, 1, 1, 0,  0, 0, 0,  0,   0));
    qa.push_back(mk( 3199,  1, 1, 1, 0,  0, 0, 0,  0,   0));
    qa.push_back(mk( 3200,  0, 1, 1, 1,  1, 0, 0,  0,   1));
    qa.push_back(mk( 3201,  0, 1, 1, 1,  0, 0, 0,  0,   1));
    qa.push_back(mk( 6400,  0, 1, 1, 1,  1, 0, 0,  0,   2));
    qa.push_back(mk( 6401,  0, 1, 1, 1,  0, 0, 0,  0,   2));

    qb.push_back(mk(    0,  0, 0, 0, 1,  0, 0, 0,  0,   0));
    qb.push_back(mk(    1,  1, 0, 0, 1,  0, 0, 0,  1,   0));
    qb.push_back(mk(    7,  1, 0, 0, 1,  0, 0, 0,  7,   0));
    qb.push_back(mk(    8,  1, 0, 0, 0,  0, 0, 0,  0,   0));
    qb.push_back(mk(    9,  1, 0, 0, 0,  0, 0, 0,  0,   0));
    qb.push_back(mk(   10,  1, 1, 0, 0,  0, 0, 0,  0,   0));
    qb.push_back(mk(   12,  1, 1, 0, 0,  0, 0, 0,  0,   0));
    qb.push_back(mk(   13,  1, 0, 0, 0,  0, 0, 0,  0,   0));
    qb.push_back(mk(   14,  1, 0, 0, 1,  1, 0, 0,  0,   1));
    qb.push_back(mk(   15,  1, 0, 0, 1,  0, 0, 0,  1,   1));
    qb.push_back(mk(   55,  1, 0, 0, 0,  0, 0, 0,  0,   0));
    qb.push_back(mk(   56,  1, 0, 0, 0,  1, 0, 0,  0,   0));
    qb.push_back(mk(   69,  1, 0, 0, 0,  0, 0, 0,  0,   0));
    qb.push_back(mk(   70,  1, 0, 1, 0,  1, 0, 0,  0,   0));
    qb.push_back(mk(   80,  1, 1, 1, 0,  0, 0, 0,  0,   0));
    qb.push_back(mk(   83,  1, 0, 1, 0,  0, 0, 0,  0,   0));
    qb.push_back(mk(   84,  1, 0, 0, 0,  1, 0, 0,  0,   0));
    qb.push_back(mk(   97,  1, 0, 0, 0,  0, 0, 0,  0,   0));
    qb.push_back(mk(   98,  1, 0, 0, 1,  1, 1, 1,  0,   0));
    qb.push_back(mk(   99,  1, 0, 0, 1,  0, 0, 1,  1,   0));
    qb.push_back(mk(  196,  1, 0, 0, 1,  1, 1, 2,  0,   0));
    qb.push_back(mk(  294,  1, 0, 0, 1,  1, 1, 3,  0,   0));
    qb.push_back(mk(  392,  1, 0, 0, 1,  1, 1, 0,  0,   0));
    qb.push_back(mk(  393,  1, 0, 0, 1,  0, 0, 0,  1,   0));

    qc.push_back(mk(    0,  0, 1, 1, 1,  0, 0, 0,  0,   0));
    qc.push_back(mk(    3,  1, 1, 1, 1,  0, 0, 0,  0,   0));
    qc.push_back(mk(    4,  0, 1, 1, 1,  0, 0, 0,  1,   0));
    qc.push_back(mk(   55,  1, 1, 1, 0,  0, 0, 0,  0,   0));
    qc.push_back(mk(   56,  0, 1, 1, 1,  1, 0, 0,  0,   1));
    qc.push_back(mk(  279,  1, 1, 1, 0,  0, 0, 0,  0,   0));
    qc.push_back(mk(  280,  0, 1, 0, 0,  1, 0, 0,  0,   0));
    qc.push_back(mk(  321,  0, 0, 0, 0,  0, 0, 0,  0,   0));

    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // C: reset mid-line, inside both syncs, on a pixel-enable cycle
    for (int i = 0; i < 2000 && cyc_c != 323; i++) @(negedge clk);
    if (cyc_c != 323) begin
      checks++;
      errors++;
      $display("FAIL C reset_point: cyc %0d, wanted 323", cyc_c);
    end
    rst_c = 1'b1;
    @(posedge clk);
    #1;
    rst_c = 1'b0;
    qc.push_back(mk(    0,  0, 1, 1, 1,  0, 0, 0,  0,   0));
    qc.push_back(mk(    1,  0, 1, 1, 1,  0, 0, 0,  0,   0));
    qc.push_back(mk(    3,  1, 1, 1, 1,  0, 0, 0,  0,   0));
    qc.push_back(mk(    4,  0, 1, 1, 1,  0, 0, 0,  1,   0));
    qc.push_back(mk(   56,  0, 1, 1, 1,  1, 0, 0,  0,   1));
    qc.push_back(mk(  391,  1, 1, 1, 0,  0, 0, 0,  0,   0));
    qc.push_back(mk(  392,  0, 1, 1, 1,  1, 1, 1,  0,   0));

    for (int i = 0; i < 20000 && (qa.size() + qb.size() + qc.size()) > 0; i++)
      @(negedge clk);
    #1;
    while (qa.size() > 0) begin ea = qa.pop_front(); missed("A", ea.cyc, cyc_a); end
    while (qb.size() > 0) begin eb = qb.pop_front(); missed("B", eb.cyc, cyc_b); end
    while (qc.size() > 0) begin ec = qc.pop_front(); missed("C", ec.cyc, cyc_c); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
